lfsr_sched: RTL and testbench

LFSR_SCHED -- requirements
Module: lfsr_sched

---
 rtl/lfsr_sched.sv | 138 +++++++++++++
 tb/tb_lfsr_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_sched.sv
// Round-robin scheduler that time-shares one serial LFSR among NUM_REQ requesters,
// packing its bits LSB-first into WORD_W-bit words, WORDS_PER_HV words per grant.
module lfsr_sched #(
    parameter int NUM_REQ      = 4,
    parameter int WORD_W       = 8,
    parameter int WORDS_PER_HV = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       lfsr_bit,
    output logic                       lfsr_en,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic [WORD_W-1:0]          word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic                       word_last,
    output logic                       busy,
    output logic [1:0]                 o_dbg_state
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(WORD_W) + 1;
    localparam int WCW = $clog2(WORDS_PER_HV) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_gnt_id;
    logic [NUM_REQ-1:0] r_gnt;
    logic [BCW-1:0]     r_bit_cnt;
    logic [WCW-1:0]     r_word_cnt;
    logic [WORD_W-1:0]  r_word;

    logic [IDW:0]       w_cand;
    logic [IDW-1:0]     w_win_id;
    logic               w_win_found;
    logic               w_bit_done;
    logic               w_word_done;
    logic               w_hs;

    // First requester at or after r_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_win_id    = '0;
        w_win_found = 1'b0;
        w_cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + (IDW+1)'(i);
            if (w_cand >= (IDW+1)'(NUM_REQ))
                w_cand = w_cand - (IDW+1)'(NUM_REQ);
            if (!w_win_found && req[w_cand[IDW-1:0]]) begin
                w_win_found = 1'b1;
                w_win_id    = w_cand[IDW-1:0];
            end
        end
    end

    // Word handshake: a word transfers on any edge where word_valid and word_ready
    // are both high; word_valid never drops and word_out/word_last never change
    // until that edge.
    assign w_hs        = (r_state == S_OUT) && word_ready;
    assign w_bit_done  = (r_bit_cnt == BCW'(WORD_W - 1));
    assign w_word_done = (r_word_cnt == WCW'(WORDS_PER_HV - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_win_found) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_bit_done)  w_state_nxt = S_OUT;
            S_OUT:   if (w_hs)        w_state_nxt = w_word_done ? S_IDLE : S_SHIFT;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_word     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_found) begin
                        for (int k = 0; k < NUM_REQ; k++)
                            r_gnt[k] <= (w_win_id == IDW'(k));
                        r_gnt_id  <= w_win_id;
                        r_bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    for (int k = 0; k < WORD_W; k++)
                        if (r_bit_cnt == BCW'(k)) r_word[k] <= lfsr_bit;
                    r_bit_cnt <= w_bit_done ? '0 : r_bit_cnt + 1'b1;
                end
                S_OUT: begin
                    if (w_hs) begin
                        if (w_word_done) begin
                            // Hypervector complete: release the grant and leave IDLE outputs all-zero.
                            r_gnt      <= '0;
                            r_gnt_id   <= '0;
                            r_word     <= '0;
                            r_word_cnt <= '0;
                            r_ptr      <= (r_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign lfsr_en     = (r_state == S_SHIFT);
    assign word_valid  = (r_state == S_OUT);
    assign word_last   = (r_state == S_OUT) && w_word_done;
    assign busy        = (r_state != S_IDLE);
    assign gnt         = r_gnt;
    assign gnt_id      = r_gnt_id;
    assign word_out    = r_word;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lfsr_sched.sv
// Directed and randomized bench for lfsr_sched with an attached 8-bit LFSR and
// a transaction-level model of arbitration and word contents.
module tb_lfsr_sched;

    localparam int NUM_REQ = 4;
    localparam int WORD_W  = 8;
    localparam int WPH     = 4;
    localparam logic [7:0] SEED = 8'b10010110;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_REQ-1:0]  req;
    logic                lfsr_bit;
    logic                lfsr_en;
    logic [NUM_REQ-1:0]  gnt;
    logic [1:0]          gnt_id;
    logic [WORD_W-1:0]   word_out;
    logic                word_valid;
    logic                word_ready;
    logic                word_last;
    logic                busy;
    logic [1:0]          dbg_state;

    logic [7:0]          lfsr_q = SEED;
    logic [WORD_W-1:0]   exp_q[$];
    int                  m_ptr;
    int                  n_checks = 0;
    int                  n_fail   = 0;

    // ---------------- clock / environment ----------------
    always #5 clk = ~clk;

    // Shared LFSR, taps {0,2,3,4}, serial output is bit 0.
    assign lfsr_bit = lfsr_q[0];
    always @(posedge clk) if (lfsr_en) lfsr_q <= {^(lfsr_q & 8'h1D), lfsr_q[7:1]};

    lfsr_sched #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W), .WORDS_PER_HV(WPH)) dut (
        .clk(clk), .rst(rst), .req(req), .lfsr_bit(lfsr_bit), .lfsr_en(lfsr_en),
        .gnt(gnt), .gnt_id(gnt_id), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .word_last(word_last), .busy(busy),
        .o_dbg_state(dbg_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- model ----------------
    // Expected words: consecutive 8-bit LSB-first slices of the LFSR bit stream.
    task automatic build_model();
        int s, word, fb;
        s = int'(SEED);
        for (int w = 0; w < 200; w++) begin
            word = 0;
            for (int b = 0; b < WORD_W; b++) begin
                word = word + ((s % 2) << b);
                fb   = (s + (s / 4) + (s / 8) + (s / 16)) % 2;
                fb   = ((s % 2) + ((s / 4) % 2) + ((s / 8) % 2) + ((s / 16) % 2)) % 2;
                s    = (s / 2) + fb * 128;
            end
            exp_q.push_back(WORD_W'(word));
        end
    endtask

    function automatic int winner(input logic [NUM_REQ-1:0] r, input int p);
        for (int i = 0; i < NUM_REQ; i++)
            if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return -1;
    endfunction

    // ---------------- checking / drivers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},    gnt, 0);
        chk({tag, "_gnt_id"}, gnt_id, 0);
        chk({tag, "_word"},   word_out, 0);
        chk({tag, "_valid"},  word_valid, 0);
        chk({tag, "_last"},   word_last, 0);
        chk({tag, "_en"},     lfsr_en, 0);
        chk({tag, "_busy"},   busy, 0);
    endtask

    // mode: 0 ready always high, 1 drop req after word 1, 2 five-cycle stall on word 2,
    // 3 random stalls. abort_word >= 0 pulses rst while that word is presented.
    task automatic do_hv(input logic [NUM_REQ-1:0] r, input int mode, input int abort_word);
        int id, shift_n, stall, en_n;
        logic [WORD_W-1:0] exp_w;
        req = r;
        chk("idle_busy", busy, 0);
        chk("idle_valid", word_valid, 0);
        chk("idle_gnt", gnt, 0);
        chk("idle_word", word_out, 0);
        id = winner(r, m_ptr);
        tick();
        chk("gnt_id", gnt_id, id);
        chk("gnt_onehot", gnt, 1 << id);
        en_n = 0;
        for (int w = 0; w < WPH; w++) begin
            shift_n = 0;
            while (word_valid !== 1'b1 && shift_n <= 2 * WORD_W) begin
                if (lfsr_en === 1'b1) en_n++;
                tick();
                shift_n++;
            end
            chk("shift_len", shift_n, WORD_W);
            if (word_valid !== 1'b1) return;
            exp_w = exp_q.pop_front();
            chk("word", word_out, exp_w);
            chk("last", word_last, w == WPH - 1);
            chk("en_out", lfsr_en, 0);
            chk("gnt_hold", gnt, 1 << id);
            if (w == abort_word) begin
                rst = 1'b1;
                #1;
                chk_all_zero("rst_mid");
                tick();
                tick();
                rst = 1'b0;
                m_ptr = 0;
                return;
            end
            if (mode == 1 && w == 0) req = '0;
            stall = (mode == 2 && w == 1) ? 5 : ((mode == 3) ? $urandom_range(0, 3) : 0);
            for (int c = 0; c < stall; c++) begin
                word_ready = 1'b0;
                tick();
                chk("bp_valid", word_valid, 1);
                chk("bp_word", word_out, exp_w);
                chk("bp_last", word_last, w == WPH - 1);
                chk("bp_en", lfsr_en, 0);
            end
            word_ready = 1'b1;
            tick();
        end
        chk("end_busy", busy, 0);
        chk("en_total", en_n, WORD_W * WPH);
        m_ptr = (id + 1) % NUM_REQ;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        build_model();
        m_ptr      = 0;
        rst        = 1'b1;
        req        = '0;
        word_ready = 1'b1;
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("noreq_busy", busy, 0);
            chk("noreq_en", lfsr_en, 0);
        end

        do_hv(4'b0010, 0, -1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 5; i++) do_hv(4'b1111, 0, -1);

        do_hv(4'b0100, 0, -1);
        do_hv(4'b0011, 0, -1);
        do_hv(4'b0011, 0, -1);

        do_hv(4'b0001, 2, -1);
        do_hv(4'b0001, 1, -1);

        do_hv(4'b0001, 0, 1);
        do_hv(4'b0100, 0, -1);

        for (int i = 0; i < 12; i++) do_hv(NUM_REQ'($urandom_range(1, 15)), 3, -1);

        req = '0;
        tick();
        chk("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
